// File: rtl/axi_addr_router_if.sv
// Address-channel bundle between one master, the routed slaves,
// and the response tracker feeding RESP_DONE.
interface axi_addr_router_if #(
    parameter int NUM_S = 7,
    parameter int AW    = 32
);
    logic           VALID;
    logic [AW-1:0]  ADDR;
    logic           READY;
    logic [NUM_S:0] VALID_SS;
    logic [NUM_S:0] READY_SS;
    logic           RESP_DONE;

    modport slave (
        input  VALID,
        input  ADDR,
        input  READY_SS,
        input  RESP_DONE,
        output READY,
        output VALID_SS
    );

    modport master (
        output VALID,
        output ADDR,
        output READY_SS,
        output RESP_DONE,
        input  READY,
        input  VALID_SS
    );
endinterface

// File: rtl/axi_addr_router.sv
// Address decoder/router: one master to NUM_S slaves plus a default
// slave, locking the target while transactions are outstanding.
package axi_addr_router_pkg;
    function automatic logic [4095:0] map_default(
        int n, int aw, bit last
    );
        logic [4095:0] r;
        logic [4095:0] v;
        logic [4095:0] m;
        r = '0;
        m = (4096'(1) << aw) - 4096'(1);
        for (int i = n - 1; i >= 0; i--) begin
            v = 4096'(i) * 4096'(65536);
            if (last)
                v = v + 4096'(65535);
            r = (r << aw) | (v & m);
        end
        return r;
    endfunction
endpackage

module axi_addr_router
    import axi_addr_router_pkg::*;
#(
    parameter int NUM_S   = 7,
    parameter int AW      = 32,
    parameter int MAX_OUT = 4,
    parameter logic [NUM_S*AW-1:0] S_BASE =
        (NUM_S*AW)'(map_default(NUM_S, AW, 1'b0)),
    parameter logic [NUM_S*AW-1:0] S_LAST =
        (NUM_S*AW)'(map_default(NUM_S, AW, 1'b1)),
    localparam int TW = $clog2(NUM_S + 1)
) (
    input  logic                ACLK,
    input  logic                ARESET,
    axi_addr_router_if.slave    bus,
    output logic [TW-1:0]       TARGET,
    output logic [3:0]          OUT_CNT,
    output logic                BUSY
);
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FULL
    } state_t;

    localparam logic [3:0] MAXC = 4'(MAX_OUT);

    state_t         state_q;
    state_t         state_d;
    logic [TW-1:0]  sel;
    logic [TW-1:0]  target_d;
    logic [3:0]     cnt_d;
    logic [NUM_S:0] vss;
    logic           stall;
    logic           accept;

    // Lowest-numbered matching window wins on overlap.
    always_comb begin
        sel = TW'(NUM_S);
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if (bus.ADDR >= S_BASE[i*AW +: AW] &&
                bus.ADDR <= S_LAST[i*AW +: AW])
                sel = TW'(i);
        end
    end

    always_comb begin
        stall = (state_q == FULL) ||
                (state_q != IDLE && sel != TARGET);
        vss = '0;
        if (!ARESET && bus.VALID && !stall)
            vss[sel] = 1'b1;
    end

    assign bus.VALID_SS = vss;
    assign bus.READY    = |(vss & bus.READY_SS);
    assign accept       = bus.READY;
    assign BUSY         = (state_q != IDLE);

    // Simultaneous accept and completion leave the count unchanged.
    always_comb begin
        cnt_d    = OUT_CNT;
        target_d = TARGET;
        state_d  = state_q;
        if (accept)
            target_d = sel;
        if (accept && !bus.RESP_DONE)
            cnt_d = OUT_CNT + 4'd1;
        else if (!accept && bus.RESP_DONE &&
                 OUT_CNT != 4'd0)
            cnt_d = OUT_CNT - 4'd1;
        unique case (1'b1)
            cnt_d == 4'd0: state_d = IDLE;
            cnt_d == MAXC: state_d = FULL;
            default:       state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            OUT_CNT <= 4'd0;
            TARGET  <= '0;
        end else begin
            state_q <= state_d;
            OUT_CNT <= cnt_d;
            TARGET  <= target_d;
        end
    end
endmodule

// File: tb/tb_axi_addr_router.sv
// Directed bench for axi_addr_router with a cycle-level reference
// model compared every cycle plus literal spot checks.
module tb_axi_addr_router;
    localparam int NS = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] target;
    logic [3:0] out_cnt;
    logic       busy;

    int errors = 0;
    int checks = 0;

    axi_addr_router_if #(.NUM_S(NS), .AW(32)) bus ();

    axi_addr_router #(
        .NUM_S  (NS),
        .AW     (32),
        .MAX_OUT(4)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus),
        .TARGET (target),
        .OUT_CNT(out_cnt),
        .BUSY   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     nm, act, exp);
        end
    endtask

    // Reference: default map is slave i owning [i*64K, i*64K+64K-1].
    int m_cnt = 0;
    int m_tgt = 0;
    bit live  = 1'b0;

    function automatic int m_sel(logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= 32'(i) * 32'h10000 &&
                a <= 32'(i) * 32'h10000 + 32'hFFFF)
                return i;
        end
        return NS;
    endfunction

    function automatic bit m_open(int s);
        return !rst && bus.VALID &&
               (m_cnt == 0 || (m_cnt < 4 && s == m_tgt));
    endfunction

    always @(posedge clk) begin
        int s;
        bit acc;
        s   = m_sel(bus.ADDR);
        acc = m_open(s) && bus.READY_SS[s];
        if (rst) begin
            m_cnt = 0;
            m_tgt = 0;
        end else begin
            if (acc)
                m_tgt = s;
            if (acc && !bus.RESP_DONE)
                m_cnt++;
            else if (bus.RESP_DONE && !acc && m_cnt > 0)
                m_cnt--;
        end
        live = 1'b1;
    end

    always @(negedge clk) begin
        int s;
        logic [7:0] ev;
        if (live) begin
            s  = m_sel(bus.ADDR);
            ev = m_open(s) ? (8'h1 << s) : 8'h0;
            chk("m_valid_ss", 32'(bus.VALID_SS), 32'(ev));
            chk("m_ready", 32'(bus.READY),
                32'(ev[s] & bus.READY_SS[s]));
            chk("m_out_cnt", 32'(out_cnt), 32'(m_cnt));
            chk("m_target", 32'(target), 32'(m_tgt));
            chk("m_busy", 32'(busy), 32'(m_cnt != 0));
        end
    end

    task automatic drive(bit v, logic [31:0] a,
                         logic [7:0] rs, bit d);
        bus.VALID     = v;
        bus.ADDR      = a;
        bus.READY_SS  = rs;
        bus.RESP_DONE = d;
    endtask

    // Apply inputs just after an edge, then wait to the sample point.
    task automatic step(bit r, bit v, logic [31:0] a,
                        logic [7:0] rs, bit d);
        @(posedge clk);
        #1;
        rst = r;
        drive(v, a, rs, d);
        @(negedge clk);
    endtask

    task automatic lit(string nm, logic [31:0] act,
                       logic [31:0] exp);
        chk(nm, act, exp);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 32'h0002_0010, 8'hFF, 1'b1);
        @(negedge clk);
        lit("rst_vss", 32'(bus.VALID_SS), 32'h0);
        lit("rst_ready", 32'(bus.READY), 32'h0);
        step(1, 0, 32'h0, 8'h00, 0);
        lit("rst_cnt", 32'(out_cnt), 32'd0);
        lit("rst_tgt", 32'(target), 32'd0);
        lit("rst_busy", 32'(busy), 32'd0);

        step(0, 1, 32'h0002_0010, 8'h04, 0);
        lit("acc2_vss", 32'(bus.VALID_SS), 32'h04);
        lit("acc2_ready", 32'(bus.READY), 32'd1);
        step(0, 0, 32'h0, 8'h00, 0);
        lit("acc2_cnt", 32'(out_cnt), 32'd1);
        lit("acc2_tgt", 32'(target), 32'd2);
        lit("acc2_busy", 32'(busy), 32'd1);

        step(0, 1, 32'h0003_0000, 8'h08, 0);
        lit("sw_stall_vss", 32'(bus.VALID_SS), 32'h0);
        lit("sw_stall_rdy", 32'(bus.READY), 32'd0);
        step(0, 1, 32'h0003_0000, 8'h08, 1);
        lit("sw_done_vss", 32'(bus.VALID_SS), 32'h0);
        step(0, 1, 32'h0003_0000, 8'h08, 0);
        lit("sw_vss", 32'(bus.VALID_SS), 32'h08);
        lit("sw_ready", 32'(bus.READY), 32'd1);
        step(0, 0, 32'h0, 8'h00, 1);
        lit("sw_tgt", 32'(target), 32'd3);
        step(0, 0, 32'h0, 8'h00, 0);
        lit("sw_idle", 32'(out_cnt), 32'd0);

        for (int i = 0; i < 4; i++)
            step(0, 1, 32'h0000_0100, 8'h01, 0);
        lit("fill_cnt3", 32'(out_cnt), 32'd3);
        step(0, 1, 32'h0000_0100, 8'h01, 0);
        lit("full_cnt", 32'(out_cnt), 32'd4);
        lit("full_vss", 32'(bus.VALID_SS), 32'h0);
        lit("full_ready", 32'(bus.READY), 32'd0);
        step(0, 1, 32'h0000_0100, 8'h01, 1);
        lit("full_done_rdy", 32'(bus.READY), 32'd0);
        step(0, 0, 32'h0, 8'h00, 1);
        lit("drain_cnt3", 32'(out_cnt), 32'd3);
        step(0, 1, 32'h0000_0100, 8'h01, 1);
        lit("both_cnt2", 32'(out_cnt), 32'd2);
        lit("both_ready", 32'(bus.READY), 32'd1);
        step(0, 0, 32'h0, 8'h00, 0);
        lit("both_hold", 32'(out_cnt), 32'd2);
        step(0, 0, 32'h0, 8'h00, 1);
        step(0, 0, 32'h0, 8'h00, 1);
        step(0, 0, 32'h0, 8'h00, 0);
        lit("drain_zero", 32'(out_cnt), 32'd0);

        step(0, 1, 32'h0001_FFFF, 8'h02, 0);
        lit("edge_vss", 32'(bus.VALID_SS), 32'h02);
        step(0, 1, 32'h0002_0000, 8'h04, 0);
        lit("edge_stall", 32'(bus.VALID_SS), 32'h0);
        step(0, 0, 32'h0, 8'h00, 1);
        step(0, 0, 32'h0, 8'h00, 0);

        step(0, 1, 32'h0010_0000, 8'h80, 0);
        lit("dflt_vss", 32'(bus.VALID_SS), 32'h80);
        lit("dflt_ready", 32'(bus.READY), 32'd1);
        step(0, 0, 32'h0, 8'h00, 0);
        lit("dflt_tgt", 32'(target), 32'd7);
        step(0, 0, 32'h0, 8'h00, 1);
        step(0, 0, 32'h0, 8'h00, 0);

        step(0, 1, 32'h0005_0000, 8'h00, 0);
        lit("wait_vss", 32'(bus.VALID_SS), 32'h20);
        lit("wait_ready", 32'(bus.READY), 32'd0);
        step(0, 0, 32'h0005_0000, 8'h20, 0);
        lit("drop_cnt", 32'(out_cnt), 32'd0);
        lit("drop_tgt", 32'(target), 32'd7);

        step(0, 0, 32'h0, 8'h00, 1);
        step(0, 0, 32'h0, 8'h00, 1);
        step(0, 0, 32'h0, 8'h00, 0);
        lit("underflow", 32'(out_cnt), 32'd0);

        for (int i = 0; i < 3; i++)
            step(0, 1, 32'h0001_0000, 8'h02, 0);
        step(1, 1, 32'h0001_0000, 8'h02, 1);
        lit("pre_rst_cnt", 32'(out_cnt), 32'd3);
        lit("mid_rst_vss", 32'(bus.VALID_SS), 32'h0);
        lit("mid_rst_rdy", 32'(bus.READY), 32'd0);
        step(0, 1, 32'h0006_0000, 8'h40, 0);
        lit("post_rst_cnt", 32'(out_cnt), 32'd0);
        lit("post_rst_tgt", 32'(target), 32'd0);
        lit("post_rst_vss", 32'(bus.VALID_SS), 32'h40);
        lit("post_rst_rdy", 32'(bus.READY), 32'd1);
        step(0, 0, 32'h0, 8'h00, 0);
        lit("post_rst_t6", 32'(target), 32'd6);
        lit("post_rst_c1", 32'(out_cnt), 32'd1);
        step(0, 0, 32'h0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
